// File: rtl/vu_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : vu_pwm_decoder
// Description : Recovers the 7-bit duty level and frame period from a
//               VU-meter PWM line. A frame starts on each rising edge. The
//               high time is rounded to the nearest duty increment and
//               saturated. A line with no rising edge for TIMEOUT_CLKS
//               cycles is reported as stuck high or stuck low.
// Revision    : 1.0 - initial release
// ============================================================================
module vu_pwm_decoder #(
  parameter int TICK_DIV     = 64,     // clk cycles per duty increment (power of 2)
  parameter int MAX_LEVEL    = 127,    // saturation value of level
  parameter int CNT_W        = 16,     // width of high/period counters
  parameter int TIMEOUT_CLKS = 16384   // cycles without a rise before stuck report
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             pwm_in,
  output logic [6:0]       level,
  output logic [CNT_W-1:0] period,
  output logic             level_valid,
  output logic             stuck
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int               c_shift     = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_timeout   = CNT_W'(TIMEOUT_CLKS);
  localparam logic [CNT_W:0]   c_half_tick = (CNT_W+1)'(TICK_DIV / 2);
  localparam logic [CNT_W:0]   c_level_sat = (CNT_W+1)'(MAX_LEVEL);
  localparam logic [6:0]       c_level_max = 7'(MAX_LEVEL);

  localparam logic [1:0] c_st_idle = 2'd0;
  localparam logic [1:0] c_st_high = 2'd1;
  localparam logic [1:0] c_st_low  = 2'd2;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic             rst_meta_q;
  logic             rst_n_q;

  logic             sync1_q;
  logic             sync2_q;
  logic             edge_q;
  logic             w_rise;
  logic             w_fall;

  logic [1:0]       state_q;
  logic [1:0]       state_d;

  logic [CNT_W-1:0] hi_q;
  logic [CNT_W-1:0] hi_d;
  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] per_d;
  logic [CNT_W-1:0] w_hi_inc;
  logic [CNT_W-1:0] w_per_inc;
  logic             skip_q;
  logic             skip_d;

  // Emit request captured on the detecting edge, consumed one clk later
  logic             emit_q;
  logic             emit_d;
  logic             emit_to_q;
  logic             emit_to_d;
  logic             emit_line_q;
  logic             emit_line_d;
  logic [CNT_W-1:0] emit_hi_q;
  logic [CNT_W-1:0] emit_hi_d;
  logic [CNT_W-1:0] emit_per_q;
  logic [CNT_W-1:0] emit_per_d;

  logic [CNT_W:0]   w_round;
  logic [6:0]       level_q;
  logic [6:0]       level_d;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] period_d;
  logic             valid_q;
  logic             valid_d;
  logic             stuck_q;
  logic             stuck_d;

  // --------------------------------------------------------------------------
  // Reset bridge: assertion is immediate, release is aligned to clk
  // --------------------------------------------------------------------------
  // Two-flop release synchronizer for the asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_meta_q <= 1'b0;
      rst_n_q    <= 1'b0;
    end else begin
      rst_meta_q <= 1'b1;
      rst_n_q    <= rst_meta_q;
    end
  end

  // --------------------------------------------------------------------------
  // Input path: two-flop synchronizer plus one delay flop for edge detect.
  // Keeps running while enable is low so the line history stays valid.
  // --------------------------------------------------------------------------
  // Synchronize pwm_in and keep one extra sample for edge detection
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= pwm_in;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign w_rise = sync2_q & ~edge_q;
  assign w_fall = ~sync2_q & edge_q;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  // State register
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      state_q <= c_st_idle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a timeout never changes state
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = c_st_idle;
    end else begin
      case (state_q)
        c_st_idle: if (w_rise) state_d = c_st_high;
        c_st_high: if (w_fall) state_d = c_st_low;
        c_st_low:  if (w_rise) state_d = c_st_high;
        default:   state_d = c_st_idle;
      endcase
    end
  end

  // FSM outputs: counter updates, recovery flag and emit request
  always_comb begin
    hi_d        = hi_q;
    per_d       = per_q;
    skip_d      = skip_q;
    emit_d      = 1'b0;
    emit_to_d   = 1'b0;
    emit_line_d = 1'b0;
    emit_hi_d   = emit_hi_q;
    emit_per_d  = emit_per_q;

    // Saturating increments
    w_hi_inc  = (hi_q  == c_cnt_max) ? hi_q  : hi_q  + c_cnt_one;
    w_per_inc = (per_q == c_cnt_max) ? per_q : per_q + c_cnt_one;

    if (!enable) begin
      hi_d       = '0;
      per_d      = '0;
      skip_d     = 1'b0;
      emit_hi_d  = '0;
      emit_per_d = '0;
    end else if (w_rise && (state_q != c_st_high)) begin
      // A rise wins over a coincident timeout. It always opens a new frame.
      // It closes the previous one only from LOW and only if that frame
      // was not interrupted by a stuck report.
      hi_d   = c_cnt_one;
      per_d  = c_cnt_one;
      skip_d = 1'b0;
      if ((state_q == c_st_low) && !skip_q) begin
        emit_d     = 1'b1;
        emit_hi_d  = hi_q;
        emit_per_d = per_q;
      end
    end else if (w_per_inc == c_timeout) begin
      // Stuck report; counters restart so the report repeats periodically
      hi_d        = '0;
      per_d       = '0;
      skip_d      = 1'b1;
      emit_d      = 1'b1;
      emit_to_d   = 1'b1;
      emit_line_d = sync2_q;
    end else begin
      per_d = w_per_inc;
      // The falling-edge clk is already low time, so hi_cnt stops there
      if ((state_q == c_st_high) && !w_fall) begin
        hi_d = w_hi_inc;
      end
    end
  end

  // Counter, recovery flag and emit request registers
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      hi_q        <= '0;
      per_q       <= '0;
      skip_q      <= 1'b0;
      emit_q      <= 1'b0;
      emit_to_q   <= 1'b0;
      emit_line_q <= 1'b0;
      emit_hi_q   <= '0;
      emit_per_q  <= '0;
    end else begin
      hi_q        <= hi_d;
      per_q       <= per_d;
      skip_q      <= skip_d;
      emit_q      <= emit_d;
      emit_to_q   <= emit_to_d;
      emit_line_q <= emit_line_d;
      emit_hi_q   <= emit_hi_d;
      emit_per_q  <= emit_per_d;
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: rounding, saturation and stuck flag
  // --------------------------------------------------------------------------
  // Compute next output values from the captured emit request
  always_comb begin
    level_d  = level_q;
    period_d = period_q;
    valid_d  = 1'b0;
    stuck_d  = stuck_q;
    // Round to nearest increment: add half a tick before truncating
    w_round  = ({1'b0, emit_hi_q} + c_half_tick) >> c_shift;

    if (!enable) begin
      level_d  = '0;
      period_d = '0;
      stuck_d  = 1'b0;
    end else if (emit_q) begin
      valid_d = 1'b1;
      if (emit_to_q) begin
        level_d  = emit_line_q ? c_level_max : 7'd0;
        period_d = '0;
        stuck_d  = 1'b1;
      end else begin
        level_d  = (w_round > c_level_sat) ? c_level_max : w_round[6:0];
        period_d = emit_per_q;
        stuck_d  = 1'b0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n_q) begin
    if (!rst_n_q) begin
      level_q  <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      stuck_q  <= 1'b0;
    end else begin
      level_q  <= level_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      stuck_q  <= stuck_d;
    end
  end

  assign level       = level_q;
  assign period      = period_q;
  assign level_valid = valid_q;
  assign stuck       = stuck_q;

endmodule
`default_nettype wire

// File: tb/tb_vu_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_vu_pwm_decoder
// Description : Directed self-checking bench for vu_pwm_decoder. The decoder
//               is run at a reduced time scale (8 clk per increment, 1024 clk
//               frames, 2048 clk timeout) so every scenario stays short.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vu_pwm_decoder;

  localparam int TICK_DIV     = 8;
  localparam int MAX_LEVEL    = 127;
  localparam int CNT_W        = 16;
  localparam int TIMEOUT_CLKS = 2048;
  localparam int FRAME        = 1024;   // 128 increments of 8 clk
  localparam int HIGH40       = 320;    // duty 40

  logic             clk = 1'b0;
  logic             reset_n;
  logic             enable;
  logic             pwm_in = 1'b0;
  logic [6:0]       level;
  logic [CNT_W-1:0] period;
  logic             level_valid;
  logic             stuck;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rise_cyc = 0;

  // Strobe log, filled by the monitor below
  int q_cyc[$];
  int q_level[$];
  int q_period[$];
  int q_stuck[$];

  always #5 clk = ~clk;

  vu_pwm_decoder #(
    .TICK_DIV    (TICK_DIV),
    .MAX_LEVEL   (MAX_LEVEL),
    .CNT_W       (CNT_W),
    .TIMEOUT_CLKS(TIMEOUT_CLKS)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .pwm_in     (pwm_in),
    .level      (level),
    .period     (period),
    .level_valid(level_valid),
    .stuck      (stuck)
  );

  // Count clk edges and record every strobe, sampled 1 time unit after the edge
  always @(posedge clk) begin
    #1;
    cyc = cyc + 1;
    if (level_valid === 1'b1) begin
      q_cyc.push_back(cyc);
      q_level.push_back(int'(level));
      q_period.push_back(int'(period));
      q_stuck.push_back(int'(stuck));
    end
  end

  task automatic clr_q;
    q_cyc.delete();
    q_level.delete();
    q_period.delete();
    q_stuck.delete();
  endtask

  // Drive the line to v for n clk; call at a falling clk edge
  task automatic seg(input logic v, input int n);
    if (v && !pwm_in) rise_cyc = cyc;
    pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input int h);
    seg(1'b1, h);
    seg(1'b0, FRAME - h);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    enable  = 1'b1;
    pwm_in  = 1'b0;
    repeat (4) @(negedge clk);
    total++; if (level !== 7'd0) begin bad++; $display("FAIL reset_level: got %0d want 0", level); end
    total++; if (period !== '0) begin bad++; $display("FAIL reset_period: got %0d want 0", period); end
    total++; if (level_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", level_valid); end
    total++; if (stuck !== 1'b0) begin bad++; $display("FAIL reset_stuck: got %b want 0", stuck); end
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL reset_nostrobe: got %0d strobes want 0", q_cyc.size()); end
  endtask

  task automatic test_nominal;
    clr_q();
    frame(HIGH40);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL nom_first_rise: got %0d strobes want 0", q_cyc.size()); end
    for (int i = 0; i < 3; i++) begin
      clr_q();
      frame(HIGH40);
      total++;
      if (q_cyc.size() != 1) begin
        bad++; $display("FAIL nom_count[%0d]: got %0d strobes want 1", i, q_cyc.size());
      end else begin
        if (q_level[0] != 40) begin bad++; $display("FAIL nom_level[%0d]: got %0d want 40", i, q_level[0]); end
        total++; if (q_period[0] != FRAME) begin bad++; $display("FAIL nom_period[%0d]: got %0d want %0d", i, q_period[0], FRAME); end
        total++; if (q_stuck[0] != 0) begin bad++; $display("FAIL nom_stuck[%0d]: got %0d want 0", i, q_stuck[0]); end
        total++; if (q_cyc[0] - rise_cyc != 4) begin bad++; $display("FAIL nom_latency[%0d]: got %0d want 4", i, q_cyc[0] - rise_cyc); end
      end
    end
  endtask

  task automatic test_duty_sweep;
    int hs[6]  = '{1, 3, 4, 1015, 1023, HIGH40};
    int exp[6] = '{0, 0, 1, 127, 127, 40};
    int prev   = 40;
    for (int j = 0; j < 6; j++) begin
      clr_q();
      frame(hs[j]);
      total++;
      if (q_cyc.size() != 1) begin
        bad++; $display("FAIL sweep_count[%0d]: got %0d strobes want 1", j, q_cyc.size());
      end else begin
        if (q_level[0] != prev) begin bad++; $display("FAIL sweep_level[%0d]: got %0d want %0d", j, q_level[0], prev); end
        total++; if (q_period[0] != FRAME) begin bad++; $display("FAIL sweep_period[%0d]: got %0d want %0d", j, q_period[0], FRAME); end
      end
      prev = exp[j];
    end
  endtask

  task automatic test_stuck_low;
    int base;
    clr_q();
    frame(HIGH40);
    base = (q_cyc.size() > 0) ? q_cyc[0] : 0;
    total++; if (q_cyc.size() != 1 || q_level[0] != 40) begin bad++; $display("FAIL slow_pre: got %0d strobes want 1 with level 40", q_cyc.size()); end
    clr_q();
    seg(1'b0, 4000);
    total++;
    if (q_cyc.size() != 2) begin
      bad++; $display("FAIL slow_count: got %0d strobes want 2", q_cyc.size());
    end else begin
      if (q_cyc[0] != base + 2047) begin bad++; $display("FAIL slow_t1: got +%0d want +2047", q_cyc[0] - base); end
      total++; if (q_cyc[1] != base + 4095) begin bad++; $display("FAIL slow_t2: got +%0d want +4095", q_cyc[1] - base); end
      for (int k = 0; k < 2; k++) begin
        total++; if (q_level[k] != 0 || q_period[k] != 0 || q_stuck[k] != 1) begin
          bad++; $display("FAIL slow_rep[%0d]: got level=%0d period=%0d stuck=%0d want 0/0/1", k, q_level[k], q_period[k], q_stuck[k]);
        end
      end
    end
    clr_q();
    frame(HIGH40);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL slow_recover_rise: got %0d strobes want 0", q_cyc.size()); end
    total++; if (stuck !== 1'b1) begin bad++; $display("FAIL slow_stuck_hold: got %b want 1", stuck); end
    clr_q();
    frame(HIGH40);
    total++;
    if (q_cyc.size() != 1 || q_level[0] != 40 || q_period[0] != FRAME || q_stuck[0] != 0) begin
      bad++; $display("FAIL slow_recovered: got %0d strobes level=%0d stuck=%b want 1 strobe level 40 stuck 0", q_cyc.size(), level, stuck);
    end
  endtask

  task automatic test_stuck_high;
    clr_q();
    seg(1'b1, 5000);
    total++;
    if (q_cyc.size() != 3) begin
      bad++; $display("FAIL shigh_count: got %0d strobes want 3", q_cyc.size());
    end else begin
      if (q_level[0] != 40 || q_stuck[0] != 0) begin bad++; $display("FAIL shigh_first: got level=%0d stuck=%0d want 40/0", q_level[0], q_stuck[0]); end
      total++; if (q_cyc[1] != q_cyc[0] + 2047) begin bad++; $display("FAIL shigh_t1: got +%0d want +2047", q_cyc[1] - q_cyc[0]); end
      total++; if (q_cyc[2] != q_cyc[0] + 4095) begin bad++; $display("FAIL shigh_t2: got +%0d want +4095", q_cyc[2] - q_cyc[0]); end
      for (int k = 1; k < 3; k++) begin
        total++; if (q_level[k] != 127 || q_period[k] != 0 || q_stuck[k] != 1) begin
          bad++; $display("FAIL shigh_rep[%0d]: got level=%0d period=%0d stuck=%0d want 127/0/1", k, q_level[k], q_period[k], q_stuck[k]);
        end
      end
    end
    clr_q();
    seg(1'b0, FRAME - HIGH40);
    frame(HIGH40);
    total++; if (q_cyc.size() != 0 || stuck !== 1'b1) begin bad++; $display("FAIL shigh_recover_rise: got %0d strobes stuck=%b want 0 strobes stuck 1", q_cyc.size(), stuck); end
    clr_q();
    frame(HIGH40);
    total++;
    if (q_cyc.size() != 1 || q_level[0] != 40 || q_period[0] != FRAME || q_stuck[0] != 0) begin
      bad++; $display("FAIL shigh_recovered: got %0d strobes level=%0d stuck=%b want 1 strobe level 40 stuck 0", q_cyc.size(), level, stuck);
    end
  endtask

  task automatic test_reset_mid;
    clr_q();
    seg(1'b1, 100);
    total++; if (q_cyc.size() != 1 || level !== 7'd40) begin bad++; $display("FAIL rmid_pre: got %0d strobes level=%0d want 1 strobe level 40", q_cyc.size(), level); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (level !== 7'd0) begin bad++; $display("FAIL rmid_level: got %0d want 0", level); end
    total++; if (period !== '0) begin bad++; $display("FAIL rmid_period: got %0d want 0", period); end
    total++; if (level_valid !== 1'b0 || stuck !== 1'b0) begin bad++; $display("FAIL rmid_flags: got valid=%b stuck=%b want 0/0", level_valid, stuck); end
    @(negedge clk);
    seg(1'b1, 219);
    reset_n = 1'b1;
    seg(1'b0, FRAME - HIGH40);
    clr_q();
    frame(HIGH40);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL rmid_first_rise: got %0d strobes want 0", q_cyc.size()); end
    clr_q();
    frame(HIGH40);
    total++;
    if (q_cyc.size() != 1 || q_level[0] != 40 || q_period[0] != FRAME) begin
      bad++; $display("FAIL rmid_second_rise: got %0d strobes level=%0d period=%0d want 1 strobe 40/%0d", q_cyc.size(), level, period, FRAME);
    end
  endtask

  task automatic test_enable_gap;
    clr_q();
    seg(1'b1, 100);
    total++; if (q_cyc.size() != 1 || level !== 7'd40) begin bad++; $display("FAIL en_pre: got %0d strobes level=%0d want 1 strobe level 40", q_cyc.size(), level); end
    enable = 1'b0;
    clr_q();
    repeat (10) @(negedge clk);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL en_gap_strobe: got %0d strobes want 0", q_cyc.size()); end
    total++; if (level !== 7'd0 || period !== '0) begin bad++; $display("FAIL en_gap_clear: got level=%0d period=%0d want 0/0", level, period); end
    enable = 1'b1;
    seg(1'b1, HIGH40 - 110);
    seg(1'b0, FRAME - HIGH40);
    frame(HIGH40);
    total++; if (q_cyc.size() != 0) begin bad++; $display("FAIL en_first_rise: got %0d strobes want 0", q_cyc.size()); end
    clr_q();
    frame(HIGH40);
    total++;
    if (q_cyc.size() != 1 || q_level[0] != 40 || q_period[0] != FRAME || q_stuck[0] != 0) begin
      bad++; $display("FAIL en_resume: got %0d strobes level=%0d period=%0d want 1 strobe 40/%0d", q_cyc.size(), level, period, FRAME);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_duty_sweep();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid();
    test_enable_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
